// File: rtl/safety_island_boot_ctrl.sv
// Hardware boot sequencer for safety-island instances: programs bootmode, entry point and
// fetch-enable over a register master port, then polls each target's EOC register.
module safety_island_boot_ctrl #(
    parameter int unsigned NumTargets    = 1,
    parameter logic [31:0] BaseAddr      = 32'h6000_0000,
    parameter logic [31:0] TargetStride  = 32'h0010_0000,
    parameter logic [31:0] BootModeOff   = 32'h0000_00C4,
    parameter logic [31:0] EntryOff      = 32'h0000_00C8,
    parameter logic [31:0] FetchEnOff    = 32'h0000_00CC,
    parameter logic [31:0] EocOff        = 32'h0000_00A0,
    parameter int unsigned PollInterval  = 64,
    parameter logic [31:0] TimeoutCycles = 32'd1_000_000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [31:0]                bootmode_i,
    input  logic [32*NumTargets-1:0]   entry_point_i,
    output logic                       req_o,
    output logic [31:0]                addr_o,
    output logic                       we_o,
    output logic [31:0]                wdata_o,
    output logic [3:0]                 be_o,
    input  logic                       gnt_i,
    input  logic                       rvalid_i,
    input  logic [31:0]                rdata_i,
    input  logic                       err_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       timeout_o,
    output logic                       bus_err_o,
    output logic [NumTargets-1:0]      eoc_o,
    output logic [31*NumTargets-1:0]   exit_status_o
);

    localparam int unsigned TW         = (NumTargets > 1) ? $clog2(NumTargets) : 1;
    localparam logic [TW-1:0] LastTgt  = TW'(NumTargets - 1);
    localparam logic [31:0]   PollLast = 32'(PollInterval - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_MODE, S_WR_ENTRY, S_WR_FETCH, S_POLL_WAIT, S_RD_EOC, S_DONE, S_ERR
    } state_e;

    state_e                         state_q, state_d;
    logic [TW-1:0]                  t_q, t_d;
    logic                           pending_q, pending_d;
    logic [31:0]                    poll_cnt_q, poll_cnt_d;
    logic [31:0]                    tmo_cnt_q, tmo_cnt_d;
    logic [31:0]                    bootmode_q, bootmode_d;
    logic [NumTargets-1:0][31:0]    entry_q, entry_d;
    logic                           done_q, done_d;
    logic                           timeout_q, timeout_d;
    logic                           bus_err_q, bus_err_d;
    logic [NumTargets-1:0]          eoc_q, eoc_d;
    logic [NumTargets-1:0][30:0]    exit_q, exit_d;
    logic [31:0]                    tgt_base;
    logic                           tmo_hit;
    logic                           slot_done;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        pending_d  = pending_q;
        poll_cnt_d = poll_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        bootmode_d = bootmode_q;
        entry_d    = entry_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        bus_err_d  = bus_err_q;
        eoc_d      = eoc_q;
        exit_d     = exit_q;
        req_o      = 1'b0;
        we_o       = 1'b0;
        addr_o     = '0;
        wdata_o    = '0;
        slot_done  = 1'b0;
        tgt_base   = BaseAddr + 32'(t_q) * TargetStride;
        tmo_hit    = (TimeoutCycles != 32'd0) && (tmo_cnt_q >= TimeoutCycles);

        if ((state_q == S_POLL_WAIT || state_q == S_RD_EOC) && tmo_cnt_q != '1) begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
        end

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    bus_err_d  = 1'b0;
                    eoc_d      = '0;
                    exit_d     = '0;
                    bootmode_d = bootmode_i;
                    entry_d    = entry_point_i;
                    t_d        = '0;
                    pending_d  = 1'b0;
                    poll_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    state_d    = S_WR_MODE;
                end
            end

            S_WR_MODE, S_WR_ENTRY, S_WR_FETCH: begin
                we_o  = 1'b1;
                req_o = !pending_q;
                if (state_q == S_WR_MODE) begin
                    addr_o  = tgt_base + BootModeOff;
                    wdata_o = bootmode_q;
                end else if (state_q == S_WR_ENTRY) begin
                    addr_o  = tgt_base + EntryOff;
                    wdata_o = entry_q[t_q];
                end else begin
                    addr_o  = tgt_base + FetchEnOff;
                    wdata_o = 32'd1;
                end
                if (!pending_q && gnt_i) begin
                    pending_d = 1'b1;
                end
                if (pending_q && rvalid_i) begin
                    pending_d = 1'b0;
                    if (err_i) begin
                        bus_err_d = 1'b1;
                        state_d   = S_ERR;
                    end else if (state_q == S_WR_MODE) begin
                        state_d = S_WR_ENTRY;
                    end else if (state_q == S_WR_ENTRY) begin
                        state_d = S_WR_FETCH;
                    end else if (t_q == LastTgt) begin
                        t_d        = '0;
                        poll_cnt_d = '0;
                        state_d    = S_POLL_WAIT;
                    end else begin
                        t_d     = t_q + 1'b1;
                        state_d = S_WR_MODE;
                    end
                end
            end

            S_POLL_WAIT: begin
                if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_ERR;
                end else if (poll_cnt_q == PollLast) begin
                    poll_cnt_d = '0;
                    state_d    = S_RD_EOC;
                end else begin
                    poll_cnt_d = poll_cnt_q + 32'd1;
                end
            end

            S_RD_EOC: begin
                addr_o = tgt_base + EocOff;
                if (eoc_q[t_q]) begin
                    slot_done = 1'b1;
                end else begin
                    req_o = !pending_q;
                    if (!pending_q && gnt_i) begin
                        pending_d = 1'b1;
                    end
                    if (pending_q && rvalid_i) begin
                        pending_d = 1'b0;
                        if (err_i) begin
                            bus_err_d = 1'b1;
                            state_d   = S_ERR;
                        end else begin
                            if (rdata_i[31]) begin
                                eoc_d[t_q]  = 1'b1;
                                exit_d[t_q] = rdata_i[30:0];
                            end
                            slot_done = 1'b1;
                        end
                    end
                end
                // Completion is checked before the timeout so a simultaneous EOC wins.
                if (slot_done) begin
                    if (&eoc_d) begin
                        done_d  = 1'b1;
                        t_d     = '0;
                        state_d = S_DONE;
                    end else if (tmo_hit) begin
                        timeout_d = 1'b1;
                        t_d       = '0;
                        state_d   = S_ERR;
                    end else if (t_q == LastTgt) begin
                        t_d        = '0;
                        poll_cnt_d = '0;
                        state_d    = S_POLL_WAIT;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            t_q        <= '0;
            pending_q  <= 1'b0;
            poll_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            bootmode_q <= '0;
            entry_q    <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            eoc_q      <= '0;
            exit_q     <= '0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            pending_q  <= pending_d;
            poll_cnt_q <= poll_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            bootmode_q <= bootmode_d;
            entry_q    <= entry_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            bus_err_q  <= bus_err_d;
            eoc_q      <= eoc_d;
            exit_q     <= exit_d;
        end
    end

    assign be_o          = 4'hF;
    assign busy_o        = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign bus_err_o     = bus_err_q;
    assign eoc_o         = eoc_q;
    assign exit_status_o = exit_q;

endmodule
